// File: rtl/cm_pipe_adder_pkg.sv
// cm_pipe_adder_pkg: shared types and helpers for the digit-pipelined adder.
// Optional subtract mode is enabled by defining CM_PIPE_ADDER_SUB_EN.
package cm_pipe_adder_pkg;

    // Widest operand the stage register layout can carry.
    localparam int CM_MAX_WIDTH = 64;

    // Number of register stages for a given operand width and digit size.
    function automatic int stages(input int width, input int digit);
        return width / digit;
    endfunction

    // One pipeline slot. Fields are sized for the widest build; a given
    // instance only uses the low WIDTH bits, the rest stay zero.
    //   sum    : result digits resolved by this and earlier stages
    //   opa_hi : operand A, digits above this stage still to be consumed
    //   opb_hi : operand B, same
    //   carry  : carry out of the digit resolved by this stage
    //   sub    : subtract select travelling with the operands
    typedef struct packed {
        logic                    valid;
        logic [CM_MAX_WIDTH-1:0] sum;
        logic [CM_MAX_WIDTH-1:0] opa_hi;
        logic [CM_MAX_WIDTH-1:0] opb_hi;
        logic                    carry;
        logic                    sub;
    } stage_t;

`ifdef CM_PIPE_ADDER_SUB_EN
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
`endif

endpackage

// File: rtl/cm_pipe_adder_if.sv
// cm_pipe_adder_if: operand and result streams of cm_pipe_adder.
// in_sub is present only when CM_PIPE_ADDER_SUB_EN is defined.
//
// Handshake: a beat transfers on the rising edge where valid && ready are
// both 1. Once valid is raised the sender keeps valid and its payload
// stable until that transfer; ready may depend combinationally on the
// other side's state, valid never depends on ready.
interface cm_pipe_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef CM_PIPE_ADDER_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    // Producer of operands and consumer of results.
    modport master (
`ifdef CM_PIPE_ADDER_SUB_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    // The adder itself.
    modport slave (
`ifdef CM_PIPE_ADDER_SUB_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/cm_add_digit.sv
// cm_add_digit: combinational DIGIT-bit ripple slice. Besides the carry out
// it reports the carry into its top bit, used for signed overflow.
module cm_add_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, cin_i};

    // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out.
    assign cmsb_o = sum_o[DIGIT-1] ^ a_i[DIGIT-1] ^ b_i[DIGIT-1];
endmodule

// File: rtl/cm_pipe_adder.sv
// cm_pipe_adder: WIDTH-bit adder split into WIDTH/DIGIT register stages,
// one DIGIT-bit slice per stage, with valid/ready streams on both sides.
// Defining CM_PIPE_ADDER_SUB_EN adds in_sub (A - B - borrow_in).
module cm_pipe_adder
    import cm_pipe_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input logic            clk,
    input logic            rst,
    cm_pipe_adder_if.slave bus
);
    localparam int STAGES = stages(WIDTH, DIGIT);

    if (WIDTH < 1 || DIGIT < 1) begin : g_bad_size
        $error("cm_pipe_adder: WIDTH and DIGIT must both be >= 1");
    end else if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("cm_pipe_adder: WIDTH must be a multiple of DIGIT");
    end
    if (WIDTH > CM_MAX_WIDTH) begin : g_too_wide
        $error("cm_pipe_adder: WIDTH exceeds CM_MAX_WIDTH");
    end

    stage_t                        stage_q [STAGES];
    stage_t                        stage_d [STAGES];
    stage_t                        src     [STAGES];
    stage_t                        in_stage;
    logic                          msb_cin_q;
    logic                          msb_cin_d;
    logic                          adv;
    logic [STAGES-1:0][DIGIT-1:0]  dig_a;
    logic [STAGES-1:0][DIGIT-1:0]  dig_b;
    logic [STAGES-1:0][DIGIT-1:0]  dig_sum;
    logic [STAGES-1:0]             dig_cin;
    logic [STAGES-1:0]             dig_cout;
    logic [STAGES-1:0]             dig_cmsb;
    logic                          unused_bits;

    // The whole pipe moves as one unless a finished result is being held.
    assign adv          = !stage_q[STAGES-1].valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage-0 source: the operand set at the input, zero-extended.
    always_comb begin
        in_stage                    = '0;
        in_stage.valid              = bus.in_valid;
        in_stage.opa_hi[WIDTH-1:0]  = bus.in_a;
        in_stage.opb_hi[WIDTH-1:0]  = bus.in_b;
`ifdef CM_PIPE_ADDER_SUB_EN
        in_stage.sub   = bus.in_sub;
        // Borrow-in becomes carry-in of the complemented subtrahend.
        in_stage.carry = (bus.in_sub == OP_SUB) ? ~bus.in_cin : bus.in_cin;
`else
        in_stage.sub   = 1'b0;
        in_stage.carry = bus.in_cin;
`endif
    end

    // Route each stage's predecessor and pick out the digit it resolves.
    always_comb begin
        src[0] = in_stage;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = stage_q[k-1];
        end
        dig_a   = '0;
        dig_b   = '0;
        dig_cin = '0;
        for (int k = 0; k < STAGES; k++) begin
            dig_a[k]   = src[k].opa_hi[k*DIGIT +: DIGIT];
`ifdef CM_PIPE_ADDER_SUB_EN
            dig_b[k]   = (src[k].sub == OP_SUB) ? ~src[k].opb_hi[k*DIGIT +: DIGIT]
                                                :  src[k].opb_hi[k*DIGIT +: DIGIT];
`else
            dig_b[k]   = src[k].opb_hi[k*DIGIT +: DIGIT];
`endif
            dig_cin[k] = src[k].carry;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slice
        cm_add_digit #(.DIGIT(DIGIT)) u_digit (
            .a_i    (dig_a[g]),
            .b_i    (dig_b[g]),
            .cin_i  (dig_cin[g]),
            .sum_o  (dig_sum[g]),
            .cout_o (dig_cout[g]),
            .cmsb_o (dig_cmsb[g])
        );
    end

    // Next slot contents: predecessor's slot with this stage's digit filled in.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k]                        = src[k];
            stage_d[k].sum[k*DIGIT +: DIGIT]  = dig_sum[k];
            stage_d[k].carry                  = dig_cout[k];
        end
        msb_cin_d = dig_cmsb[STAGES-1];
    end

    // Pipeline registers: cleared by reset, otherwise shift together on adv.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            msb_cin_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            msb_cin_q <= msb_cin_d;
        end
    end

    assign bus.out_valid = stage_q[STAGES-1].valid;
    assign bus.out_sum   = stage_q[STAGES-1].sum[WIDTH-1:0];
    assign bus.out_cout  = stage_q[STAGES-1].carry;
    assign bus.out_ovf   = stage_q[STAGES-1].carry ^ msb_cin_q;

    // Fold slot bits that this configuration never looks at (upper padding,
    // consumed operand digits, inner-slice top carries) into one sink.
    always_comb begin
        unused_bits = ^dig_cmsb;
        for (int k = 0; k < STAGES; k++) begin
            unused_bits = unused_bits ^ (^stage_q[k]);
        end
    end
endmodule
